// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: latch enables/flushes and PC control from hazards, misses, redirects and halt.
// Optional PIPE_PERF_EN adds stall_cycles / flush_count performance counters.
module hazard_ctrl #(
    parameter int REGW = 5,
    parameter int CNTW = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_dREN,
    input  logic            mem_dWEN,
    input  logic            ex_memRead,
    input  logic [REGW-1:0] ex_rd,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            ex_redirect,
    input  logic            wb_halt,
    output logic            pc_en,
    output logic            pc_redirect,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            idex_en,
    output logic            idex_flush,
    output logic            exmem_en,
    output logic            exmem_flush,
    output logic            memwb_en,
    output logic            memwb_flush,
`ifdef PIPE_PERF_EN
    output logic [CNTW-1:0] stall_cycles,
    output logic [CNTW-1:0] flush_count,
`endif
    output logic            halted
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t state, state_n;
    logic   dpend;
    logic   luse;
    logic   active;

    if (CNTW < 1 || REGW < 1) begin : g_param_chk
        $error("hazard_ctrl: REGW and CNTW must be positive");
    end

    assign dpend  = (mem_dREN | mem_dWEN) & ~dhit;
    assign luse   = ex_memRead & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign active = (state != HALT);
    assign halted = (state == HALT);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        priority case (1'b1)
            !active: state_n = HALT;
            wb_halt: state_n = HALT;
            dpend:   state_n = DWAIT;
            default: state_n = RUN;
        endcase
    end

    // A flushed latch is also enabled: it loads the bubble, never freezes.
    always_comb begin
        pc_en       = 1'b0;
        pc_redirect = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        exmem_flush = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        if (active && !wb_halt && !dpend) begin
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            idex_en  = 1'b1;
            priority case (1'b1)
                ex_redirect: begin
                    pc_en       = 1'b1;
                    pc_redirect = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                end
                luse: begin
                    idex_flush = 1'b1;
                end
                !ihit: begin
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                end
                default: begin
                    pc_en   = 1'b1;
                    ifid_en = 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (active) begin
            if (!pc_en) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
            if (pc_redirect) begin
                flush_count <= flush_count + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus
// multi-cycle miss, redirect, halt, reset and perf-counter sequences.
module tb_hazard_ctrl;

    localparam int REGW = 5;
    localparam int CNTW = 32;

    localparam logic [9:0] NORM  = 10'b10_10_10_10_10;
    localparam logic [9:0] FRZ   = 10'b00_00_00_00_00;
    localparam logic [9:0] IMISS = 10'b00_11_10_10_10;
    localparam logic [9:0] LUSE  = 10'b00_00_11_10_10;
    localparam logic [9:0] REDIR = 10'b11_11_11_10_10;

    logic            CLK = 1'b0;
    logic            nRST;
    logic            ihit, dhit, mem_dREN, mem_dWEN, ex_memRead;
    logic [REGW-1:0] ex_rd, id_rs1, id_rs2;
    logic            ex_redirect, wb_halt;
    logic            pc_en, pc_redirect;
    logic            ifid_en, ifid_flush, idex_en, idex_flush;
    logic            exmem_en, exmem_flush, memwb_en, memwb_flush;
    logic            halted;
`ifdef PIPE_PERF_EN
    logic [CNTW-1:0] stall_cycles, flush_count;
`endif
    logic [9:0]      ctl;

    int n_chk  = 0;
    int n_fail = 0;

    hazard_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .ihit        (ihit),
        .dhit        (dhit),
        .mem_dREN    (mem_dREN),
        .mem_dWEN    (mem_dWEN),
        .ex_memRead  (ex_memRead),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .ex_redirect (ex_redirect),
        .wb_halt     (wb_halt),
        .pc_en       (pc_en),
        .pc_redirect (pc_redirect),
        .ifid_en     (ifid_en),
        .ifid_flush  (ifid_flush),
        .idex_en     (idex_en),
        .idex_flush  (idex_flush),
        .exmem_en    (exmem_en),
        .exmem_flush (exmem_flush),
        .memwb_en    (memwb_en),
        .memwb_flush (memwb_flush),
`ifdef PIPE_PERF_EN
        .stall_cycles(stall_cycles),
        .flush_count (flush_count),
`endif
        .halted      (halted)
    );

    always #5 CLK = ~CLK;

    assign ctl = {pc_en, pc_redirect, ifid_en, ifid_flush, idex_en,
                  idex_flush, exmem_en, exmem_flush, memwb_en, memwb_flush};

    typedef struct {
        string           name;
        logic            ih, dh, drd, dwr, mr;
        logic [REGW-1:0] rd, rs1, rs2;
        logic            rdr;
        logic [9:0]      exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic ih, input logic dh, input logic drd,
                         input logic dwr, input logic mr,
                         input logic [REGW-1:0] rd, input logic [REGW-1:0] rs1,
                         input logic [REGW-1:0] rs2, input logic rdr,
                         input logic hlt);
        ihit = ih; dhit = dh; mem_dREN = drd; mem_dWEN = dwr;
        ex_memRead = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        ex_redirect = rdr; wb_halt = hlt;
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle();
        #1;
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_ctl", {22'd0, ctl}, {22'd0, NORM});
        step();
        nRST = 1'b1;
        step();
    endtask

    initial begin
        tbl[0]  = '{"idle",          1,0,0,0,0, 0,0,0, 0, NORM};
        tbl[1]  = '{"imiss",         0,0,0,0,0, 0,0,0, 0, IMISS};
        tbl[2]  = '{"luse_rs2",      1,0,0,0,1, 5,1,5, 0, LUSE};
        tbl[3]  = '{"luse_rs1",      1,0,0,0,1, 7,7,2, 0, LUSE};
        tbl[4]  = '{"luse_rd0",      1,0,0,0,1, 0,0,0, 0, NORM};
        tbl[5]  = '{"no_load",       1,0,0,0,0, 5,5,5, 0, NORM};
        tbl[6]  = '{"luse_imiss",    0,0,0,0,1, 3,3,0, 0, LUSE};
        tbl[7]  = '{"redir_all",     0,0,0,0,1, 5,0,5, 1, REDIR};
        tbl[8]  = '{"redir_only",    1,0,0,0,0, 0,0,0, 1, REDIR};
        tbl[9]  = '{"store_hit",     1,1,0,1,0, 0,0,0, 0, NORM};
        tbl[10] = '{"store_miss",    1,0,0,1,0, 0,0,0, 1, FRZ};
        tbl[11] = '{"load_hit_wait", 1,1,1,0,0, 0,0,0, 0, NORM};

        nRST = 1'b0;
        idle();
        step();
        do_reset();

        for (int i = 0; i < 12; i++) begin
            step();
            drive(tbl[i].ih, tbl[i].dh, tbl[i].drd, tbl[i].dwr, tbl[i].mr,
                  tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].rdr, 0);
            #1;
            chk(tbl[i].name, {22'd0, ctl}, {22'd0, tbl[i].exp});
        end

        // load miss: three frozen cycles, then the hit advances everything
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk("miss_freeze", {22'd0, ctl}, {22'd0, FRZ});
        end
        step();
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("miss_release", {22'd0, ctl}, {22'd0, NORM});
        step();
        idle();
        #1;
        chk("miss_back_run", {22'd0, ctl}, {22'd0, NORM});

        // redirect held during a miss is taken on the hit cycle
        step();
        drive(0, 0, 1, 0, 1, 5, 5, 0, 1, 0);
        #1;
        chk("redir_in_miss", {22'd0, ctl}, {22'd0, FRZ});
        step();
        #1;
        chk("redir_in_miss2", {22'd0, ctl}, {22'd0, FRZ});
        step();
        drive(0, 1, 1, 0, 1, 5, 5, 0, 1, 0);
        #1;
        chk("redir_on_hit", {22'd0, ctl}, {22'd0, REDIR});

        // reset in the middle of a stall returns to RUN
        step();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        do_reset();
        step();
        idle();
        #1;
        chk("rst_mid_stall", {22'd0, ctl}, {22'd0, NORM});

        // halt beats miss and redirect, then sticks until reset
        step();
        drive(1, 0, 1, 0, 0, 0, 0, 0, 1, 1);
        #1;
        chk("halt_cycle", {22'd0, ctl}, {22'd0, FRZ});
        chk("halt_not_yet", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            drive(1, 1, i[0], 0, 0, 0, 0, 0, i[1], 0);
            #1;
            chk("halt_hold", {22'd0, ctl}, {22'd0, FRZ});
            chk("halted", {31'd0, halted}, 32'd1);
        end
        step();
        do_reset();
        idle();
        #1;
        chk("post_halt_ctl", {22'd0, ctl}, {22'd0, NORM});

`ifdef PIPE_PERF_EN
        do_reset();
        chk("perf_rst_stall", stall_cycles, 32'd0);
        chk("perf_rst_flush", flush_count, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        end
        step();
        drive(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 1, 4, 4, 0, 0, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        idle();
        #1;
        chk("perf_stall", stall_cycles, 32'd4);
        chk("perf_flush", flush_count, 32'd2);
        step();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step();
        idle();
        for (int i = 0; i < 3; i++) step();
        #1;
        chk("perf_halt_freeze", stall_cycles, 32'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
